// File: rtl/fir_out_stage_if.sv
// Stream bundle between the FIR output stage and its producer/consumer.
// The producer side drives filter results in and takes conditioned samples out.
interface fir_out_stage_if #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 16
);
    logic                        in_valid;
    logic signed [IN_WIDTH-1:0]  in_data;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [OUT_WIDTH-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/fir_out_stage.sv
// Rounds, saturates and decimates the FIR result, then buffers kept samples in a
// first-word-fall-through FIFO with sticky saturation/overflow flags.
module fir_out_stage #(
    parameter int IN_WIDTH   = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int FRAC_SHIFT = 15,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    fir_out_stage_if.slave                bus,
    input  logic                          clr_flags,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          sat_flag,
    output logic                          ovf_flag
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECIM - 1);
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);

    // Half an output LSB; shifting first keeps FRAC_SHIFT=0 free of a negative shift.
    localparam logic signed [IN_WIDTH:0] RND =
        ((IN_WIDTH+1)'(1) << FRAC_SHIFT) >> 1;
    localparam logic signed [IN_WIDTH:0] SAT_MAX =
        {{(IN_WIDTH+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [IN_WIDTH:0] SAT_MIN =
        {{(IN_WIDTH+2-OUT_WIDTH){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic signed [IN_WIDTH:0]    rounded;
    logic signed [IN_WIDTH:0]    shifted;
    logic                        sat_hi;
    logic                        sat_lo;
    logic signed [OUT_WIDTH-1:0] cond_data;
    logic                        keep;
    logic                        sat_event;

    logic [DCNT_W-1:0]           dcnt;
    logic                        stage_valid;
    logic signed [OUT_WIDTH-1:0] stage_data;

    logic signed [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]            wr_ptr;
    logic [PTR_W-1:0]            rd_ptr;
    logic [LVL_W-1:0]            level;
    logic                        has_data;
    logic                        full;
    logic                        pop;
    logic                        push_ok;
    logic                        ovf_event;

    always_comb begin
        rounded   = $signed({bus.in_data[IN_WIDTH-1], bus.in_data}) + RND;
        shifted   = rounded >>> FRAC_SHIFT;
        sat_hi    = shifted > SAT_MAX;
        sat_lo    = shifted < SAT_MIN;
        cond_data = shifted[OUT_WIDTH-1:0];
        if (sat_hi) begin
            cond_data = OUT_MAX;
        end else if (sat_lo) begin
            cond_data = OUT_MIN;
        end
        keep      = bus.in_valid && (dcnt == '0);
        sat_event = keep && (sat_hi || sat_lo);
    end

    // A push into a full FIFO is only accepted when the head leaves on the same edge.
    always_comb begin
        has_data  = (level != '0);
        full      = (level == LVL_FULL);
        pop       = has_data && bus.out_ready;
        push_ok   = stage_valid && (!full || pop);
        ovf_event = stage_valid && full && !pop;
    end

    assign bus.out_valid = has_data;
    assign bus.out_data  = has_data ? mem[rd_ptr] : '0;
    assign fifo_level    = level;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dcnt        <= '0;
            stage_valid <= 1'b0;
            stage_data  <= '0;
        end else begin
            stage_valid <= keep;
            if (keep) begin
                stage_data <= cond_data;
            end
            if (bus.in_valid) begin
                dcnt <= (dcnt == DCNT_LAST) ? '0 : dcnt + DCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= stage_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // A set event on the same edge as clr_flags leaves the flag set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
            ovf_flag <= 1'b0;
        end else begin
            sat_flag <= sat_event || (sat_flag && !clr_flags);
            ovf_flag <= ovf_event || (ovf_flag && !clr_flags);
        end
    end
endmodule

// File: tb/tb_fir_out_stage.sv
// Bench for fir_out_stage: a DECIM=4 and a DECIM=1 instance share one stimulus
// stream and are compared every cycle against a queue-level behavioural model.
module tb_fir_out_stage;
    localparam int IN_WIDTH   = 32;
    localparam int OUT_WIDTH  = 16;
    localparam int FRAC_SHIFT = 15;
    localparam int FIFO_DEPTH = 4;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [31:0]      in_data;
    logic             out_ready;
    logic             clr_flags;
    logic [LVL_W-1:0] level_a, level_b;
    logic             sat_a, sat_b, ovf_a, ovf_b;

    fir_out_stage_if #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus_a ();
    fir_out_stage_if #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus_b ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_data   = in_data;
    assign bus_a.out_ready = out_ready;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.in_data   = in_data;
    assign bus_b.out_ready = out_ready;

    fir_out_stage #(
        .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .FRAC_SHIFT(FRAC_SHIFT),
        .DECIM(4), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a), .clr_flags(clr_flags),
        .fifo_level(level_a), .sat_flag(sat_a), .ovf_flag(ovf_a)
    );

    fir_out_stage #(
        .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .FRAC_SHIFT(FRAC_SHIFT),
        .DECIM(1), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .clr_flags(clr_flags),
        .fifo_level(level_b), .sat_flag(sat_b), .ovf_flag(ovf_b)
    );

    always #5 clk = ~clk;

    int  decim [2] = '{4, 1};
    int  m_buf [2][FIFO_DEPTH];
    int  m_lvl [2];
    int  m_cnt [2];
    bit  m_stage_v [2];
    int  m_stage_d [2];
    bit  m_sat [2];
    bit  m_ovf [2];

    int          vectors     = 0;
    int          miscompares = 0;
    bit          rec         = 0;
    logic [15:0] got [$];

    logic [31:0] rnd_in  [4] = '{32'h0000_4000, 32'h0000_3FFF, 32'hFFFF_C000, 32'h3FFF_8000};
    logic [15:0] rnd_exp [4] = '{16'd1, 16'd0, 16'd0, 16'd32767};

    // Reference conditioning with wide integer arithmetic.
    function automatic void condition(input logic [31:0] x, output int val, output bit sat);
        longint r, s, hi, lo;
        hi = (longint'(1) <<< (OUT_WIDTH - 1)) - 1;
        lo = -(longint'(1) <<< (OUT_WIDTH - 1));
        r  = longint'($signed(x)) + (longint'(1) <<< (FRAC_SHIFT - 1));
        s  = r >>> FRAC_SHIFT;
        sat = 1'b0;
        if (s > hi) begin
            val = int'(hi);
            sat = 1'b1;
        end else if (s < lo) begin
            val = int'(lo);
            sat = 1'b1;
        end else begin
            val = int'(s);
        end
    endfunction

    function automatic void model_step(int i);
        bit pop, push, ovf_ev, kept, sat_ev;
        int v;
        if (!rst_n) begin
            m_lvl[i] = 0; m_cnt[i] = 0; m_stage_v[i] = 0; m_stage_d[i] = 0;
            m_sat[i] = 0; m_ovf[i] = 0;
            return;
        end
        pop    = (m_lvl[i] != 0) && out_ready;
        push   = m_stage_v[i];
        ovf_ev = push && (m_lvl[i] == FIFO_DEPTH) && !pop;
        if (pop) begin
            for (int k = 0; k < FIFO_DEPTH - 1; k++) m_buf[i][k] = m_buf[i][k+1];
            m_lvl[i]--;
        end
        if (push && !ovf_ev) begin
            m_buf[i][m_lvl[i]] = m_stage_d[i];
            m_lvl[i]++;
        end
        kept   = in_valid && ((m_cnt[i] % decim[i]) == 0);
        sat_ev = 1'b0;
        if (kept) begin
            condition(in_data, v, sat_ev);
            m_stage_d[i] = v;
        end
        m_stage_v[i] = kept;
        if (in_valid) m_cnt[i]++;
        m_sat[i] = sat_ev || (m_sat[i] && !clr_flags);
        m_ovf[i] = ovf_ev || (m_ovf[i] && !clr_flags);
    endfunction

    function automatic logic [31:0] exp_head(int i);
        return (m_lvl[i] != 0) ? {16'b0, 16'(m_buf[i][0])} : 32'b0;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check_output("a_valid", 32'(bus_a.out_valid), 32'(m_lvl[0] != 0));
        check_output("a_data",  {16'b0, bus_a.out_data}, exp_head(0));
        check_output("a_level", 32'(level_a), 32'(m_lvl[0]));
        check_output("a_sat",   32'(sat_a), 32'(m_sat[0]));
        check_output("a_ovf",   32'(ovf_a), 32'(m_ovf[0]));
        check_output("b_valid", 32'(bus_b.out_valid), 32'(m_lvl[1] != 0));
        check_output("b_data",  {16'b0, bus_b.out_data}, exp_head(1));
        check_output("b_level", 32'(level_b), 32'(m_lvl[1]));
        check_output("b_sat",   32'(sat_b), 32'(m_sat[1]));
        check_output("b_ovf",   32'(ovf_b), 32'(m_ovf[1]));
    endtask

    task automatic apply_stimulus(input bit v, input logic [31:0] d, input bit rdy, input bit clr);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        clr_flags = clr;
        if (rec && bus_a.out_valid && out_ready) got.push_back(bus_a.out_data);
        for (int i = 0; i < 2; i++) model_step(i);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        apply_stimulus(0, 32'h0, 0, 0);
        rst_n = 1'b1;
    endtask

    task automatic check_got(input string tag, input int n, input logic [15:0] e0,
                             input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] e3);
        logic [15:0] exp [4];
        logic [15:0] obs;
        exp = '{e0, e1, e2, e3};
        check_output({tag, "_count"}, 32'(got.size()), 32'(n));
        for (int k = 0; k < n; k++) begin
            obs = (k < got.size()) ? got[k] : 16'hxxxx;
            check_output({tag, "_value"}, {16'b0, obs}, {16'b0, exp[k]});
        end
    endtask

    initial begin
        logic [31:0] d;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_flags = 1'b0;
        do_reset();
        check_output("reset_valid", 32'(bus_a.out_valid), 32'd0);
        check_output("reset_level", 32'(level_a), 32'd0);

        // Rounding on the keep-every-sample instance.
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(1, rnd_in[k], 0, 0);
            apply_stimulus(0, 32'h0, 0, 0);
            check_output("round_data", {16'b0, bus_b.out_data}, {16'b0, rnd_exp[k]});
            apply_stimulus(0, 32'h0, 1, 0);
        end
        check_output("round_nosat", 32'(sat_b), 32'd0);

        // Saturation, flag clear, and set winning over clear.
        apply_stimulus(1, 32'h4000_0000, 0, 0);
        apply_stimulus(0, 32'h0, 0, 0);
        check_output("sat_pos_data", {16'b0, bus_b.out_data}, 32'h7FFF);
        check_output("sat_pos_flag", 32'(sat_b), 32'd1);
        apply_stimulus(0, 32'h0, 1, 0);
        apply_stimulus(1, 32'hC000_0000, 0, 0);
        apply_stimulus(0, 32'h0, 0, 0);
        check_output("sat_neg_data", {16'b0, bus_b.out_data}, 32'h8000);
        apply_stimulus(0, 32'h0, 1, 1);
        check_output("sat_clear", 32'(sat_b), 32'd0);
        apply_stimulus(1, 32'h4000_0000, 1, 1);
        check_output("sat_set_wins", 32'(sat_b), 32'd1);
        apply_stimulus(0, 32'h0, 1, 0);
        apply_stimulus(0, 32'h0, 1, 0);

        // Decimation by 4 with a free-running consumer.
        do_reset();
        got.delete();
        rec = 1;
        for (int k = 0; k < 12; k++) begin
            apply_stimulus(1, 32'(k << 15), 1, 0);
            if (k == 0) check_output("latency_c1", 32'(bus_a.out_valid), 32'd0);
            if (k == 1) check_output("latency_c2", 32'(bus_a.out_valid), 32'd1);
        end
        for (int k = 0; k < 3; k++) apply_stimulus(0, 32'h0, 1, 0);
        rec = 0;
        check_got("decim", 3, 16'd0, 16'd4, 16'd8, 16'd0);

        // Backpressure until the FIFO overflows, then drain.
        do_reset();
        for (int k = 0; k < 24; k++) apply_stimulus(1, 32'(k << 15), 0, 0);
        check_output("bp_level", 32'(level_a), 32'd4);
        check_output("bp_ovf", 32'(ovf_a), 32'd1);
        got.delete();
        rec = 1;
        for (int k = 0; k < 6; k++) apply_stimulus(0, 32'h0, 1, 0);
        rec = 0;
        check_got("bp_drain", 4, 16'd0, 16'd4, 16'd8, 16'd12);
        check_output("bp_empty", 32'(bus_a.out_valid), 32'd0);

        // Push into a full FIFO on the same edge as a pop.
        do_reset();
        for (int k = 0; k < 17; k++) apply_stimulus(1, 32'(k << 15), 0, 0);
        check_output("full_level", 32'(level_a), 32'd4);
        apply_stimulus(0, 32'h0, 1, 0);
        check_output("pushpop_level", 32'(level_a), 32'd4);
        check_output("pushpop_ovf", 32'(ovf_a), 32'd0);
        check_output("pushpop_head", {16'b0, bus_a.out_data}, 32'd4);
        got.delete();
        rec = 1;
        for (int k = 0; k < 5; k++) apply_stimulus(0, 32'h0, 1, 0);
        rec = 0;
        check_got("pushpop_drain", 4, 16'd4, 16'd8, 16'd12, 16'd16);

        // Reset with three entries stored and one in the stage register.
        do_reset();
        apply_stimulus(1, 32'h4000_0000, 0, 0);
        for (int k = 1; k < 13; k++) apply_stimulus(1, 32'(k << 15), 0, 0);
        check_output("pre_rst_level", 32'(level_a), 32'd3);
        check_output("pre_rst_sat", 32'(sat_a), 32'd1);
        rst_n = 1'b0;
        apply_stimulus(0, 32'h0, 0, 0);
        rst_n = 1'b1;
        check_output("mid_rst_valid", 32'(bus_a.out_valid), 32'd0);
        check_output("mid_rst_level", 32'(level_a), 32'd0);
        check_output("mid_rst_sat", 32'(sat_a), 32'd0);
        apply_stimulus(1, 32'(7 << 15), 0, 0);
        apply_stimulus(0, 32'h0, 0, 0);
        check_output("post_rst_keep", {16'b0, bus_a.out_data}, 32'd7);

        // Randomized traffic including occasional resets and flag clears.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            d = $urandom;
            case ($urandom_range(0, 3))
                0:       d = {{8{d[23]}}, d[23:0]};
                1:       d = {{17{d[14]}}, d[14:0]};
                2:       d = 32'h3FFF_8000 + {{24{d[7]}}, d[7:0]};
                default: d = d;
            endcase
            rst_n = ($urandom_range(0, 149) != 0);
            apply_stimulus($urandom_range(0, 3) != 0, d, $urandom_range(0, 1) == 1,
                           $urandom_range(0, 15) == 0);
        end
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
